// File: rtl/main_memory.sv
// rtl/main_memory.sv - single-byte main memory with fixed access latency
// Optional MEM_STATS_EN adds saturating completed-read/write counters.
module main_memory #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_busy,
   output logic              mem_rvalid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_wack
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
   logic              resp_entry;

   // The edge that moves WAIT -> RESP is where the access actually happens.
   assign resp_entry = (state == S_WAIT) && (cnt == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_busy   <= 1'b0;
         mem_rvalid <= 1'b0;
         mem_wack   <= 1'b0;
         mem_rdata  <= '0;
      end else begin
         mem_rvalid <= 1'b0;
         mem_wack   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (mem_req) begin
                  we_q     <= mem_we;
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  cnt      <= 4'(LAT - 1);
                  state    <= S_WAIT;
                  mem_busy <= 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_RESP;
                  if (we_q) begin
                     mem_wack <= 1'b1;
                  end else begin
                     mem_rvalid <= 1'b1;
                     mem_rdata  <= mem[addr_q];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state    <= S_IDLE;
               mem_busy <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               mem_busy <= 1'b0;
            end
         endcase
      end
   end

   // Array contents survive reset; a write caught by reset is simply dropped.
   always_ff @(posedge clk) begin
      if (resp_entry && we_q && !rst) begin
         mem[addr_q] <= wdata_q;
      end
   end

`ifdef MEM_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (resp_entry) begin
         if (we_q) begin
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         end else begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_main_memory.sv
// tb/tb_main_memory.sv - randomized bench for main_memory against a transaction-level model
// Stats checks compile in when MEM_STATS_EN is defined.
module tb_main_memory;

   localparam int LAT0 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, we0, req1, we1;
   logic [11:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        busy0, rvalid0, wack0, busy1, rvalid1, wack1;
   logic [7:0]  rdata0, rdata1;
`ifdef MEM_STATS_EN
   logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

   main_memory #(.ADDR_W(12), .DATA_W(8), .LAT(LAT0)) dut0 (
      .clk(clk), .rst(rst), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
      .mem_wdata(wdata0), .mem_busy(busy0), .mem_rvalid(rvalid0),
      .mem_rdata(rdata0), .mem_wack(wack0)
`ifdef MEM_STATS_EN
      , .rd_count(rdc0), .wr_count(wrc0)
`endif
   );

   main_memory #(.ADDR_W(12), .DATA_W(8), .LAT(1)) dut1 (
      .clk(clk), .rst(rst), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wdata1), .mem_busy(busy1), .mem_rvalid(rvalid1),
      .mem_rdata(rdata1), .mem_wack(wack1)
`ifdef MEM_STATS_EN
      , .rd_count(rdc1), .wr_count(wrc1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Transaction model for dut0: one outstanding access, accepted only when idle.
   int          cyc = 0;
   bit          m_active = 1'b0;
   int          m_e0 = 0;
   bit          m_we = 1'b0;
   logic [11:0] m_addr = '0;
   logic [7:0]  m_data = '0;
   logic [7:0]  m_rdata = 8'h00;
   logic [7:0]  m_mem [int];
   int          m_rd = 0;
   int          m_wr = 0;

   always @(posedge clk) begin
      bit was;
      cyc++;
      if (rst) begin
         m_active = 1'b0;
         m_rdata  = 8'h00;
         m_rd     = 0;
         m_wr     = 0;
      end else begin
         was = m_active;
         if (m_active && cyc == m_e0 + LAT0) begin
            if (m_we) begin
               m_mem[int'(m_addr)] = m_data;
               if (m_wr < 65535) m_wr++;
            end else begin
               m_rdata = m_mem.exists(int'(m_addr)) ? m_mem[int'(m_addr)] : 'x;
               if (m_rd < 65535) m_rd++;
            end
         end
         if (m_active && cyc == m_e0 + LAT0 + 1) m_active = 1'b0;
         if (!was && req0) begin
            m_active = 1'b1;
            m_e0     = cyc;
            m_we     = we0;
            m_addr   = addr0;
            m_data   = wdata0;
         end
      end
   end

   always @(negedge clk) begin
      bit pulse;
      if (!rst) begin
         pulse = m_active && (cyc == m_e0 + LAT0);
         check("busy", 32'(busy0), 32'(m_active));
         check("rvalid", 32'(rvalid0), 32'(pulse && !m_we));
         check("wack", 32'(wack0), 32'(pulse && m_we));
         check("rdata", 32'(rdata0), 32'(m_rdata));
`ifdef MEM_STATS_EN
         check("rd_count", 32'(rdc0), 32'(m_rd));
         check("wr_count", 32'(wrc0), 32'(m_wr));
`endif
      end
   end

   // lat = negedges from driving the request to seeing the pulse (LAT+1 when idle).
   task automatic txn(input int sel, input bit we, input logic [11:0] a, input logic [7:0] d,
                      input bit wiggle, output int lat, output logic [7:0] rd);
      int n;
      bit got;
      @(negedge clk);
      if (sel == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      n   = 0;
      got = 1'b0;
      rd  = 8'h00;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (sel == 0 ? (rvalid0 | wack0) : (rvalid1 | wack1)) begin
            got = 1'b1;
            rd  = (sel == 0) ? rdata0 : rdata1;
         end else if (wiggle && n == 1) begin
            if (sel == 0) begin addr0 = ~a; wdata0 = ~d; end
            else          begin addr1 = ~a; wdata1 = ~d; end
         end
      end
      if (sel == 0) req0 = 1'b0; else req1 = 1'b0;
      lat = got ? n : -1;
      check("response_timeout", 32'(got), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [7:0]  rd;
      logic [11:0] written [$];
      bit          we;
      logic [11:0] a;

      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_rvalid", 32'(rvalid0), 32'd0);
      check("rst_wack", 32'(wack0), 32'd0);
      check("rst_rdata", 32'(rdata0), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 32'(busy0), 32'd0);
      end

      txn(0, 1'b1, 12'h123, 8'hA5, 1'b0, lat, rd);
      check("wr_latency", 32'(lat), 32'd4);
      txn(0, 1'b0, 12'h123, 8'h00, 1'b0, lat, rd);
      check("rd_latency", 32'(lat), 32'd4);
      check("rd_A5", 32'(rd), 32'hA5);

      txn(1, 1'b1, 12'hFFF, 8'h3C, 1'b0, lat, rd);
      check("lat1_wr_latency", 32'(lat), 32'd2);
      txn(1, 1'b0, 12'hFFF, 8'h00, 1'b0, lat, rd);
      check("lat1_rd_latency", 32'(lat), 32'd2);
      check("lat1_rd_3C", 32'(rd), 32'h3C);

      txn(0, 1'b1, 12'h200, 8'h5A, 1'b0, lat, rd);
      txn(0, 1'b0, 12'h200, 8'h00, 1'b1, lat, rd);
      check("busy_req_ignored", 32'(rd), 32'h5A);

      txn(0, 1'b1, 12'h010, 8'h11, 1'b0, lat, rd);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 8'h77;
      repeat (2) @(negedge clk);
      check("midwr_busy", 32'(busy0), 32'd1);
      #2 rst = 1'b1;
      req0 = 1'b0;
      @(negedge clk);
      check("midwr_rst_busy", 32'(busy0), 32'd0);
      check("midwr_rst_wack", 32'(wack0), 32'd0);
      rst = 1'b0;
      txn(0, 1'b0, 12'h010, 8'h00, 1'b0, lat, rd);
      check("midwr_old_data", 32'(rd), 32'h11);
      written.push_back(12'h123);
      written.push_back(12'h200);
      written.push_back(12'h010);

`ifdef MEM_STATS_EN
      @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) txn(0, 1'b1, 12'h300 + 12'(i), 8'(i + 1), 1'b0, lat, rd);
      for (int i = 0; i < 2; i++) txn(0, 1'b0, 12'h300 + 12'(i), 8'h00, 1'b0, lat, rd);
      @(negedge clk);
      check("stats_wr3", 32'(wrc0), 32'd3);
      check("stats_rd2", 32'(rdc0), 32'd2);
`endif

      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         we = (written.size() == 0) || ($urandom_range(0, 1) == 1);
         a  = we ? 12'($urandom) : written[$urandom_range(0, written.size() - 1)];
         txn(0, we, a, 8'($urandom), ($urandom_range(0, 3) == 0), lat, rd);
         check("rand_latency", 32'(lat), 32'(LAT0 + 1));
         if (we) written.push_back(a);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
